keystream_xor_pipe: RTL

- Parametrised successor to the fixed 4-stage PRBS delay/XOR end stage.
- Buffers keystream words from the PRBS generator in a small FIFO and pairs each one with a plaintext word through valid/ready handshakes.
- Emits XORed or bypassed data from a registered output stage and tracks message framing.
- Sits between the PRBS generator / plaintext source and the ciphertext sink.

---
 rtl/ks_pkg.sv | 15 +
 rtl/ks_fifo.sv | 57 +++++
 rtl/keystream_xor_pipe.sv | 127 ++++++++++++
 3 files changed

// File: rtl/ks_pkg.sv
// Shared types and constants for the keystream XOR pipeline.
package ks_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic MODE_XOR    = 1'b0;
    localparam logic MODE_BYPASS = 1'b1;

    localparam int DEFAULT_DATA_W = 128;

endpackage

// File: rtl/ks_fifo.sv
// Small synchronous FIFO that buffers keystream words; DEPTH must be a power of 2.
module ks_fifo #(
    parameter  int DATA_W = 128,
    parameter  int DEPTH  = 4,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int FILL_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              clear,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic              full,
    output logic              empty,
    output logic [FILL_W-1:0] fill
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (fill == FILL_W'(DEPTH));
    assign empty   = (fill == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of 2.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            fill   <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            fill   <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   fill <= fill + 1'b1;
                2'b01:   fill <= fill - 1'b1;
                default: fill <= fill;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/keystream_xor_pipe.sv
// Pairs buffered keystream words with plaintext words and emits XORed or
// bypassed data from a registered output stage, tracking message framing.
module keystream_xor_pipe
    import ks_pkg::*;
#(
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int KS_DEPTH = 4,
    parameter int CNT_W    = 5
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              flush,
    input  logic              mode,
    input  logic              ks_valid,
    input  logic [DATA_W-1:0] ks_data,
    output logic              ks_ready,
    input  logic              pt_valid,
    input  logic [DATA_W-1:0] pt_data,
    input  logic              pt_last,
    output logic              pt_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  blk_count,
    output logic              msg_done
);

    localparam int FILL_W = $clog2(KS_DEPTH) + 1;

    state_t            state;
    logic              mode_q;
    logic              eff_mode;
    logic              slot_free;
    logic              ks_ok;
    logic              fire;
    logic              ks_push;
    logic              ks_pop;
    logic              ks_full;
    logic              ks_empty;
    logic [FILL_W-1:0] ks_fill;
    logic [DATA_W-1:0] ks_head;
    logic              last_hs;

    ks_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (KS_DEPTH)
    ) u_ks_fifo (
        .clk   (clk),
        .n_rst (n_rst),
        .clear (flush),
        .push  (ks_push),
        .din   (ks_data),
        .pop   (ks_pop),
        .head  (ks_head),
        .full  (ks_full),
        .empty (ks_empty),
        .fill  (ks_fill)
    );

    // Mode is only live while idle; mid-message the latched value rules.
    assign eff_mode  = (state == IDLE) ? mode : mode_q;
    assign slot_free = !out_valid || out_ready;
    assign ks_ok     = !ks_empty || (eff_mode == MODE_BYPASS);
    assign pt_ready  = slot_free && ks_ok && (state != DONE);
    assign fire      = pt_valid && pt_ready;
    assign ks_ready  = (ks_fill < FILL_W'(KS_DEPTH));
    assign ks_push   = ks_valid && !ks_full;
    assign ks_pop    = fire && (eff_mode == MODE_XOR);
    assign last_hs   = out_valid && out_ready && out_last;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= IDLE;
            mode_q    <= MODE_XOR;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            blk_count <= '0;
            msg_done  <= 1'b0;
        end else if (flush) begin
            state     <= IDLE;
            mode_q    <= MODE_XOR;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            blk_count <= '0;
            msg_done  <= 1'b0;
        end else begin
            msg_done <= 1'b0;

            if (fire) begin
                out_valid <= 1'b1;
                out_data  <= (eff_mode == MODE_BYPASS) ? pt_data : (pt_data ^ ks_head);
                out_last  <= pt_last;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            // DONE blocks new fires until the last word has left the output stage.
            case (state)
                IDLE: begin
                    if (fire) begin
                        mode_q    <= mode;
                        blk_count <= CNT_W'(1);
                        state     <= pt_last ? DONE : STREAM;
                    end
                end
                STREAM: begin
                    if (fire) begin
                        blk_count <= blk_count + 1'b1;
                        if (pt_last) state <= DONE;
                    end
                end
                DONE: begin
                    if (last_hs) begin
                        msg_done  <= 1'b1;
                        blk_count <= '0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
